// File: rtl/byte_inc_sched_pkg.sv
// Shared types and constants for the byte_inc job scheduler.
package byte_inc_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_RESP
  } sched_state_t;

  typedef enum logic [1:0] {
    ST_OK        = 2'd0,
    ST_ZERO_LEN  = 2'd1,
    ST_RANGE_ERR = 2'd2
  } done_status_t;

  localparam int STAT_W = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after last_grant+1.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic            clk_i,
  input  logic            arst_n_i,
  input  logic [N-1:0]    req,
  input  logic            en,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] idx;
  logic            found;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
    for (int i = 1; i <= N; i++) begin
      idx = ID_W'((int'(last_grant) + i) % N);
      if (!found && req[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
    if (en && found) grant[grant_id] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      last_grant <= ID_W'(N - 1);
    end else if (en && found) begin
      last_grant <= grant_id;
    end
  end

endmodule

// File: rtl/byte_inc_sched.sv
// Job scheduler for the byte_inc engine: round-robin grant, range check, engine launch, completion report.
// Optional statistics counters are built when BYTE_INC_SCHED_STATS_EN is defined.
module byte_inc_sched
  import byte_inc_sched_pkg::*;
#(
  parameter  int ADDR_WIDTH = 10,
  parameter  int BYTE_CNT   = 4,
  parameter  int REQ_CNT    = 4,
  localparam int ID_W       = $clog2(REQ_CNT)
) (
  input  logic                          clk_i,
  input  logic                          arst_n_i,
  input  logic [REQ_CNT-1:0]            req_valid_i,
  output logic [REQ_CNT-1:0]            req_ready_o,
  input  logic [REQ_CNT*ADDR_WIDTH-1:0] req_base_addr_i,
  input  logic [REQ_CNT*ADDR_WIDTH-1:0] req_length_i,
  output logic                          eng_run_o,
  output logic [ADDR_WIDTH-1:0]         eng_base_addr_o,
  output logic [ADDR_WIDTH-1:0]         eng_length_o,
  input  logic                          eng_waitrequest_i,
  output logic                          done_valid_o,
  output logic [ID_W-1:0]               done_id_o,
  output logic [1:0]                    done_status_o,
  output logic                          busy_o
`ifdef BYTE_INC_SCHED_STATS_EN
  ,
  output logic [REQ_CNT*STAT_W-1:0]     stat_jobs_o,
  output logic [STAT_W-1:0]             stat_err_o,
  output logic [STAT_W-1:0]             stat_busy_o
`endif
);

  localparam int                      SHIFT = $clog2(BYTE_CNT);
  localparam logic [ADDR_WIDTH:0]     ROUND = (ADDR_WIDTH+1)'(BYTE_CNT - 1);
  localparam logic [ADDR_WIDTH+1:0]   LIMIT = (ADDR_WIDTH+2)'(1) << ADDR_WIDTH;

  sched_state_t            state_q, state_d;
  logic [ID_W-1:0]         id_q;
  logic [ADDR_WIDTH-1:0]   base_q, len_q;
  done_status_t            status_q, chk_status;

  logic                    arb_en, xfer;
  logic [REQ_CNT-1:0]      grant;
  logic [ID_W-1:0]         grant_id;
  logic [ADDR_WIDTH-1:0]   sel_base, sel_len;
  logic [ADDR_WIDTH:0]     words;
  logic [ADDR_WIDTH+1:0]   end_addr;

  // Reset also blocks the grant so the ready vector reads zero while reset is held.
  assign arb_en      = (state_q == S_IDLE) && !eng_waitrequest_i && arst_n_i;
  assign xfer        = |grant;
  assign req_ready_o = grant;

  rr_arbiter #(.N(REQ_CNT)) u_arb (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .req      (req_valid_i),
    .en       (arb_en),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign sel_base = req_base_addr_i[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_len  = req_length_i[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign words    = ({1'b0, sel_len} + ROUND) >> SHIFT;
  assign end_addr = {2'b00, sel_base} + {1'b0, words};

  always_comb begin
    chk_status = ST_OK;
    if (sel_len == '0)          chk_status = ST_ZERO_LEN;
    else if (end_addr > LIMIT)  chk_status = ST_RANGE_ERR;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (xfer) state_d = (chk_status == ST_OK) ? S_ISSUE : S_RESP;
      S_ISSUE:     state_d = S_WAIT_ACK;
      S_WAIT_ACK:  if (eng_waitrequest_i)  state_d = S_WAIT_DONE;
      S_WAIT_DONE: if (!eng_waitrequest_i) state_d = S_RESP;
      S_RESP:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      id_q     <= '0;
      base_q   <= '0;
      len_q    <= '0;
      status_q <= ST_OK;
    end else if (xfer) begin
      id_q     <= grant_id;
      base_q   <= sel_base;
      len_q    <= sel_len;
      status_q <= chk_status;
    end
  end

  always_comb begin
    eng_run_o       = 1'b0;
    eng_base_addr_o = '0;
    eng_length_o    = '0;
    done_valid_o    = 1'b0;
    done_id_o       = '0;
    done_status_o   = '0;
    busy_o          = (state_q != S_IDLE);
    case (state_q)
      S_ISSUE: begin
        eng_run_o       = 1'b1;
        eng_base_addr_o = base_q;
        eng_length_o    = len_q;
      end
      S_RESP: begin
        done_valid_o  = 1'b1;
        done_id_o     = id_q;
        done_status_o = status_q;
      end
      default: ;
    endcase
  end

`ifdef BYTE_INC_SCHED_STATS_EN
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic [STAT_W-1:0] jobs_q [REQ_CNT];
  logic [STAT_W-1:0] err_q, busy_cnt_q;
  logic              resp_ok, resp_err;

  assign resp_ok  = (state_q == S_RESP) && (status_q == ST_OK);
  assign resp_err = (state_q == S_RESP) && (status_q == ST_RANGE_ERR);

  // NOTE: this small counter array is flop-based and cleared on reset, unlike a RAM which would not be.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int i = 0; i < REQ_CNT; i++) jobs_q[i] <= '0;
      err_q      <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (resp_ok && jobs_q[id_q] != STAT_MAX) jobs_q[id_q] <= jobs_q[id_q] + STAT_W'(1);
      if (resp_err && err_q != STAT_MAX)       err_q <= err_q + STAT_W'(1);
      if (busy_o && busy_cnt_q != STAT_MAX)    busy_cnt_q <= busy_cnt_q + STAT_W'(1);
    end
  end

  for (genvar g = 0; g < REQ_CNT; g++) begin : g_stat
    assign stat_jobs_o[g*STAT_W +: STAT_W] = jobs_q[g];
  end
  assign stat_err_o  = err_q;
  assign stat_busy_o = busy_cnt_q;
`endif

endmodule

// File: tb/tb_byte_inc_sched.sv
// Randomised and directed bench for byte_inc_sched, checked against a job-level reference model.
module tb_byte_inc_sched;
  import byte_inc_sched_pkg::*;

  localparam int AW = 10;
  localparam int BC = 4;
  localparam int RC = 4;
  localparam int IW = 2;

  logic clk_i_tb = 1'b0;
  always #5 clk_i_tb = ~clk_i_tb;

  logic              arst_n;
  logic [RC-1:0]     req_valid;
  logic [RC-1:0]     req_ready;
  logic [RC*AW-1:0]  req_base, req_len;
  logic              eng_run;
  logic [AW-1:0]     eng_base, eng_len;
  logic              eng_waitrequest;
  logic              done_valid;
  logic [IW-1:0]     done_id;
  logic [1:0]        done_status;
  logic              busy;
`ifdef BYTE_INC_SCHED_STATS_EN
  logic [RC*32-1:0]  stat_jobs;
  logic [31:0]       stat_err, stat_busy;
`endif

  byte_inc_sched #(.ADDR_WIDTH(AW), .BYTE_CNT(BC), .REQ_CNT(RC)) dut (
    .clk_i             (clk_i_tb),
    .arst_n_i          (arst_n),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_base_addr_i   (req_base),
    .req_length_i      (req_len),
    .eng_run_o         (eng_run),
    .eng_base_addr_o   (eng_base),
    .eng_length_o      (eng_len),
    .eng_waitrequest_i (eng_waitrequest),
    .done_valid_o      (done_valid),
    .done_id_o         (done_id),
    .done_status_o     (done_status),
    .busy_o            (busy)
`ifdef BYTE_INC_SCHED_STATS_EN
    ,
    .stat_jobs_o       (stat_jobs),
    .stat_err_o        (stat_err),
    .stat_busy_o       (stat_busy)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Engine stand-in: waitrequest rises the cycle after run and stays high for one cycle per word.
  logic eng_force = 1'b0;
  logic eng_wr    = 1'b0;
  int   eng_left  = 0;
  bit   eng_pend  = 1'b0;
  int   eng_words = 0;
  assign eng_waitrequest = eng_force | eng_wr;

  initial forever begin
    @(posedge clk_i_tb);
    #1;
    if (eng_force) begin
      eng_left = 0; eng_pend = 1'b0; eng_wr = 1'b0;
    end else begin
      if (eng_left > 0) begin
        eng_left--;
        if (eng_left == 0) eng_wr = 1'b0;
      end
      if (eng_pend) begin
        eng_wr = 1'b1; eng_left = eng_words; eng_pend = 1'b0;
      end
    end
    if (eng_run === 1'b1) begin
      eng_pend  = 1'b1;
      eng_words = (int'(eng_len) + BC - 1) / BC;
      if (eng_words == 0) eng_words = 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference model, tracked per job rather than per FSM state.
  int           cyc = 0;
  int           m_ptr;
  bit           m_act, m_ok, m_hi, m_dk;
  int           m_t, m_h, m_done, m_id;
  logic [AW-1:0] m_base, m_len;
  done_status_t m_st;
  int           m_jobs [RC];
  int           m_err, m_busy;

  int           grants[$];
  int           run_cnt = 0;
  int           run_cyc, done_cyc, grant_cyc;
  int           last_id;
  done_status_t last_st;
  bit           xfer_flag;
  int           xfer_id;

  function automatic done_status_t ref_status(int base, int len);
    if (len == 0) return ST_ZERO_LEN;
    if (base + (len + BC - 1) / BC > (1 << AW)) return ST_RANGE_ERR;
    return ST_OK;
  endfunction

  function automatic int ref_pick(int ptr, logic [RC-1:0] v);
    for (int k = 1; k <= RC; k++)
      if (v[(ptr + k) % RC]) return (ptr + k) % RC;
    return -1;
  endfunction

  task automatic model_reset();
    m_act = 1'b0; m_ptr = RC - 1; m_err = 0; m_busy = 0;
    for (int i = 0; i < RC; i++) m_jobs[i] = 0;
  endtask

  task automatic step();
    int pick;
    logic [RC-1:0] exp_rdy;
    bit exp_run, exp_done;
    #1;
    pick = (!m_act && !eng_waitrequest) ? ref_pick(m_ptr, req_valid) : -1;
    exp_rdy = '0;
    if (pick >= 0) exp_rdy[pick] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    xfer_flag = 1'b0;
    if (m_act && m_ok && cyc >= m_t + 2) begin
      if (!m_hi) begin
        if (eng_waitrequest) begin m_hi = 1'b1; m_h = cyc; end
      end else if (!m_dk && cyc > m_h && !eng_waitrequest) begin
        m_dk = 1'b1; m_done = cyc + 1;
      end
    end
    if (pick >= 0) begin
      m_act = 1'b1; m_t = cyc; m_id = pick; m_ptr = pick;
      m_base = req_base[pick*AW +: AW];
      m_len  = req_len[pick*AW +: AW];
      m_st   = ref_status(int'(m_base), int'(m_len));
      m_ok   = (m_st == ST_OK);
      m_hi   = 1'b0;
      m_dk   = !m_ok;
      m_done = cyc + 1;
      grants.push_back(pick);
      xfer_flag = 1'b1; xfer_id = pick; grant_cyc = cyc;
    end
    @(posedge clk_i_tb);
    cyc++;
    #4;
    if (m_act && m_dk && cyc > m_done) m_act = 1'b0;
    exp_run  = m_act && m_ok && (cyc == m_t + 1);
    exp_done = m_act && m_dk && (cyc == m_done);
    check("eng_run",     64'(eng_run),     64'(exp_run));
    check("eng_base",    64'(eng_base),    exp_run  ? 64'(m_base) : 64'd0);
    check("eng_len",     64'(eng_len),     exp_run  ? 64'(m_len)  : 64'd0);
    check("done_valid",  64'(done_valid),  64'(exp_done));
    check("done_id",     64'(done_id),     exp_done ? 64'(m_id)   : 64'd0);
    check("done_status", 64'(done_status), exp_done ? 64'(m_st)   : 64'd0);
    check("busy",        64'(busy),        64'(m_act));
    if (m_act) m_busy++;
    if (exp_done) begin
      if (m_st == ST_OK) m_jobs[m_id]++;
      else if (m_st == ST_RANGE_ERR) m_err++;
    end
    if (eng_run)    begin run_cnt++; run_cyc = cyc; end
    if (done_valid) begin last_id = int'(done_id); last_st = done_status_t'(done_status); done_cyc = cyc; end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((m_act || busy) && k < 200) begin step(); k++; end
    check("idle_timeout", 64'(k < 200), 64'd1);
  endtask

  task automatic submit(input int id, input int base, input int len);
    bit ok = 1'b0;
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_base[id*AW +: AW] = AW'(base);
    req_len[id*AW +: AW]  = AW'(len);
    for (int k = 0; k < 50; k++) begin
      step();
      if (xfer_flag) begin ok = 1'b1; break; end
    end
    req_valid = '0;
    check("submit_timeout", 64'(ok), 64'd1);
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"},  64'(req_ready),   64'd0);
    check({tag, "_run"},    64'(eng_run),     64'd0);
    check({tag, "_base"},   64'(eng_base),    64'd0);
    check({tag, "_len"},    64'(eng_len),     64'd0);
    check({tag, "_done"},   64'(done_valid),  64'd0);
    check({tag, "_id"},     64'(done_id),     64'd0);
    check({tag, "_status"}, 64'(done_status), 64'd0);
    check({tag, "_busy"},   64'(busy),        64'd0);
`ifdef BYTE_INC_SCHED_STATS_EN
    check({tag, "_sjobs"},  64'(|stat_jobs),  64'd0);
    check({tag, "_serr"},   64'(stat_err),    64'd0);
    check({tag, "_sbusy"},  64'(stat_busy),   64'd0);
`endif
  endtask

  task automatic do_reset();
    arst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i_tb);
    #4;
    arst_n = 1'b1;
  endtask

  initial begin
    int rc0;
    bit ok;
    arst_n = 1'b0; req_valid = '0; req_base = '0; req_len = '0;
    model_reset();
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk_i_tb);
    #4;
    arst_n = 1'b1;

    // Single job: 15 bytes = 4 words.
    rc0 = run_cnt;
    submit(0, 'h010, 15);
    check("single_runs",   64'(run_cnt - rc0),       64'd1);
    check("single_id",     64'(last_id),             64'd0);
    check("single_status", 64'(last_st),             64'(ST_OK));
    check("single_lat",    64'(done_cyc - run_cyc),  64'd6);

    // Round-robin with every requester permanently valid.
    do_reset();
    grants.delete();
    req_valid = '1;
    for (int i = 0; i < RC; i++) begin
      req_base[i*AW +: AW] = AW'(i * 'h40);
      req_len[i*AW +: AW]  = AW'(8);
    end
    for (int k = 0; k < 300 && grants.size() < 8; k++) step();
    req_valid = '0;
    wait_idle();
    check("rr_count", 64'(grants.size()), 64'd8);
    for (int i = 0; i < 8; i++) check("rr_order", 64'(grants[i]), 64'(i % RC));
`ifdef BYTE_INC_SCHED_STATS_EN
    for (int i = 0; i < RC; i++) check("rr_stat_jobs", 64'(stat_jobs[i*32 +: 32]), 64'd2);
`endif

    // Zero length: answered at T+1, engine untouched.
    rc0 = run_cnt;
    submit(2, 'h100, 0);
    check("zero_runs",   64'(run_cnt - rc0),         64'd0);
    check("zero_id",     64'(last_id),               64'd2);
    check("zero_status", 64'(last_st),               64'(ST_ZERO_LEN));
    check("zero_lat",    64'(done_cyc - grant_cyc),  64'd1);

    // Range boundary cases.
    submit(3, 'h3F8, 32);
    check("range_exact", 64'(last_st), 64'(ST_OK));
    rc0 = run_cnt;
    submit(3, 'h3F8, 40);
    check("range_over",  64'(last_st), 64'(ST_RANGE_ERR));
    submit(1, 'h3FF, 5);
    check("range_top",   64'(last_st), 64'(ST_RANGE_ERR));
    check("range_runs",  64'(run_cnt - rc0), 64'd0);

    // Engine busy while idle blocks the grant.
    eng_force = 1'b1;
    req_valid = '0; req_valid[1] = 1'b1;
    req_base[1*AW +: AW] = AW'('h020); req_len[1*AW +: AW] = AW'(4);
    for (int k = 0; k < 6; k++) begin
      step();
      check("busy_eng_ready", 64'(req_ready), 64'd0);
    end
    eng_force = 1'b0;
    step();
    check("busy_eng_grant", 64'(xfer_flag), 64'd1);
    check("busy_eng_id",    64'(xfer_id),   64'd1);
    req_valid = '0;
    wait_idle();

    // Reset while the engine is mid-job.
    req_valid = '0; req_valid[0] = 1'b1;
    req_base[0 +: AW] = AW'(0); req_len[0 +: AW] = AW'(40);
    ok = 1'b0;
    for (int k = 0; k < 20 && !xfer_flag; k++) step();
    req_valid = '0;
    for (int k = 0; k < 20; k++) begin
      if (m_hi && cyc > m_h) begin ok = 1'b1; break; end
      step();
    end
    check("mid_reach_wait", 64'(ok), 64'd1);
    eng_force = 1'b1;
    arst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    model_reset();
    repeat (2) @(posedge clk_i_tb);
    #4;
    arst_n = 1'b1;
    req_valid = 4'b0011;
    req_base[1*AW +: AW] = AW'('h050); req_len[1*AW +: AW] = AW'(4);
    for (int k = 0; k < 5; k++) begin
      step();
      check("mid_hold_ready", 64'(req_ready), 64'd0);
    end
    eng_force = 1'b0;
    step();
    check("mid_first_grant", 64'(xfer_flag), 64'd1);
    check("mid_first_id",    64'(xfer_id),   64'd0);
    req_valid = '0;
    wait_idle();

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < RC; i++) begin
        req_valid[i] = ($urandom_range(0, 2) == 0);
        req_base[i*AW +: AW] = AW'(($urandom_range(0, 3) == 0) ? $urandom_range(1000, 1023)
                                                              : $urandom_range(0, 1023));
        req_len[i*AW +: AW]  = AW'(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40));
      end
      eng_force = ($urandom_range(0, 15) == 0);
      step();
    end
    req_valid = '0;
    eng_force = 1'b0;
    wait_idle();
`ifdef BYTE_INC_SCHED_STATS_EN
    for (int i = 0; i < RC; i++) check("rand_stat_jobs", 64'(stat_jobs[i*32 +: 32]), 64'(m_jobs[i]));
    check("rand_stat_err",  64'(stat_err),  64'(m_err));
    check("rand_stat_busy", 64'(stat_busy), 64'(m_busy));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
